// File: rtl/io_pkg.sv
// Shared definitions for the io_arb block.
// Port-block register map, no-op code, FSM states and command bundle.
package io_pkg;

    localparam logic [2:0] PA     = 3'd0;
    localparam logic [2:0] DDRA   = 3'd1;
    localparam logic [2:0] PB     = 3'd2;
    localparam logic [2:0] DDRB   = 3'd3;
    localparam logic [2:0] IO_NOP = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    // Upper half of the address space has no port register behind it.
    function automatic logic is_nop(input logic [2:0] a);
        return a[2];
    endfunction

endpackage

// File: rtl/io_arb_rr_arb2.sv
// Two-way tie-break for io_arb.
// A lone requester wins; on a tie the one that did not go last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       any
);

    // Purely combinational pick
    always_comb begin
        any    = |req;
        winner = (&req) ? ~last_owner : req[1];
    end

endmodule

// File: rtl/io_arb.sv
// Two-requester arbiter in front of the port block.
// One access per three cycles: capture, issue, respond.
module io_arb
    import io_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [2:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_done,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [2:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_done,
    output logic [7:0] m1_rdata,
    output logic       io_we_n,
    output logic [2:0] io_a,
    output logic [7:0] io_di,
    input  logic [7:0] io_do,
    output logic       busy,
    output logic       owner
);

    state_t state;
    state_t state_nx;
    logic   last_owner;
    logic   winner;
    logic   any;
    logic   rd_q;
    cmd_t   cmd;

    rr_arb2 u_arb (
        .req        ({m1_req, m0_req}),
        .last_owner (last_owner),
        .winner     (winner),
        .any        (any)
    );

    // Command of whichever requester wins this cycle
    always_comb begin
        cmd = winner ? {m1_we, m1_addr, m1_wdata}
                     : {m0_we, m0_addr, m0_wdata};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = any ? ISSUE : IDLE;
            ISSUE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture the command at grant and retire it after the issue cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            io_we_n    <= 1'b1;
            io_a       <= IO_NOP;
            io_di      <= 8'h00;
            rd_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        owner <= winner;
                        if (is_nop(cmd.addr)) begin
                            io_we_n <= 1'b1;
                            io_a    <= IO_NOP;
                            rd_q    <= 1'b0;
                        end else begin
                            io_we_n <= ~cmd.we;
                            io_a    <= cmd.addr;
                            rd_q    <= ~cmd.we;
                            if (cmd.we) io_di <= cmd.wdata;
                        end
                    end
                end
                ISSUE: begin
                    io_we_n <= 1'b1;
                    io_a    <= IO_NOP;
                end
                RESP: begin
                    last_owner <= owner;
                end
                default: begin
                    io_we_n <= 1'b1;
                    io_a    <= IO_NOP;
                end
            endcase
        end
    end

    // Completion pulse and read data to the owner only
    always_comb begin
        logic [7:0] resp;
        busy     = (state != IDLE);
        m0_done  = 1'b0;
        m1_done  = 1'b0;
        m0_rdata = 8'h00;
        m1_rdata = 8'h00;
        resp     = rd_q ? io_do : 8'h00;
        if (state == RESP) begin
            if (owner) begin
                m1_done  = 1'b1;
                m1_rdata = resp;
            end else begin
                m0_done  = 1'b1;
                m0_rdata = resp;
            end
        end
    end

endmodule

// File: tb/tb_io_arb.sv
// Scoreboard bench for io_arb.
// Expected completions and port commands are queued at issue time.
module tb_io_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m0_req = 0, m0_we = 0;
    logic [2:0] m0_addr = 0;
    logic [7:0] m0_wdata = 0;
    logic       m1_req = 0, m1_we = 0;
    logic [2:0] m1_addr = 0;
    logic [7:0] m1_wdata = 0;
    logic       m0_done, m1_done;
    logic [7:0] m0_rdata, m1_rdata;
    logic       io_we_n;
    logic [2:0] io_a;
    logic [7:0] io_di;
    logic [7:0] io_do = 8'h00;
    logic       busy, owner;

    io_arb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_done  (m0_done),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_done  (m1_done),
        .m1_rdata (m1_rdata),
        .io_we_n  (io_we_n),
        .io_a     (io_a),
        .io_di    (io_di),
        .io_do    (io_do),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         who;
        logic [7:0] rdata;
    } resp_t;

    typedef struct {
        logic       we;
        logic [2:0] a;
        logic [7:0] di;
    } port_t;

    resp_t rq[$];
    port_t pq[$];
    int    dcyc[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    ndone = 0;
    logic [7:0] mem [4];
    resp_t e;
    port_t p;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Port block model: read data registered on the issue edge
    always @(posedge clk) begin
        cyc++;
        if (io_a != 3'b111) begin
            if (!io_we_n) mem[io_a[1:0]] <= io_di;
            io_do <= mem[io_a[1:0]];
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_done || m1_done) begin
                ndone++;
                dcyc.push_back(cyc);
                chk("both_done", {31'd0, m0_done & m1_done}, 0);
                if (rq.size() == 0) begin
                    chk("unexp_done", 1, 0);
                end else begin
                    e = rq.pop_front();
                    chk("done_who", {31'd0, m1_done}, {31'd0, e.who});
                    chk("owner", {31'd0, owner}, {31'd0, e.who});
                    chk("rdata", e.who ? m1_rdata : m0_rdata, e.rdata);
                    chk("other_rdata", e.who ? m0_rdata : m1_rdata, 0);
                end
            end else begin
                chk("idle_rdata", {m0_rdata, m1_rdata}, 0);
            end
        end
    end

    // Port command monitor
    always @(negedge clk) begin
        if (rst_n && (io_we_n == 1'b0 || io_a != 3'b111)) begin
            if (pq.size() == 0) begin
                chk("unexp_port", {29'd0, io_a}, 7);
            end else begin
                p = pq.pop_front();
                chk("port_we", {31'd0, ~io_we_n}, {31'd0, p.we});
                chk("port_a", {29'd0, io_a}, {29'd0, p.a});
                if (p.we) chk("port_di", {24'd0, io_di}, {24'd0, p.di});
            end
        end
    end

    task automatic set_m(input bit who, input logic req, input logic we,
                         input logic [2:0] a, input logic [7:0] d);
        if (who) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    task automatic expect_acc(input bit who, input logic we,
                              input logic [2:0] a, input logic [7:0] d,
                              input logic [7:0] rd);
        rq.push_back('{who, rd});
        if (!a[2]) pq.push_back('{we, a, d});
    endtask

    task automatic wait_done(input int n0, input int cnt, input int lim,
                             input string name);
        int i;
        for (i = 0; i < lim && ndone < n0 + cnt; i++) begin
            @(negedge clk);
            #1;
        end
        if (ndone < n0 + cnt) chk({name, "_timeout"}, ndone, n0 + cnt);
    endtask

    // One single-requester access, called 1 time unit after a negedge
    task automatic access(input bit who, input logic we, input logic [2:0] a,
                          input logic [7:0] d, input logic [7:0] rd,
                          input string name);
        int n0, start;
        n0 = ndone;
        start = cyc;
        expect_acc(who, we, a, d, rd);
        set_m(who, 1'b1, we, a, d);
        @(negedge clk);
        #1;
        chk({name, "_busy"}, {31'd0, busy}, 1);
        wait_done(n0, 1, 20, name);
        set_m(who, 1'b0, 1'b0, 3'd0, 8'h00);
        if (ndone > n0) chk({name, "_lat"}, dcyc[dcyc.size() - 1] - start, 2);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int n0;
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_owner", {31'd0, owner}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_we_n", {31'd0, io_we_n}, 1);
        chk("rst_a", {29'd0, io_a}, 7);
        chk("rst_di", {24'd0, io_di}, 0);
        chk("rst_done", {30'd0, m1_done, m0_done}, 0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Both hold req from reset: m0, m1, m0, m1
        n0 = ndone;
        dcyc.delete();
        expect_acc(0, 1, 3'd2, 8'h33, 8'h00);
        expect_acc(1, 0, 3'd2, 8'h00, 8'h33);
        expect_acc(0, 1, 3'd2, 8'h33, 8'h00);
        expect_acc(1, 0, 3'd2, 8'h00, 8'h33);
        set_m(0, 1, 1, 3'd2, 8'h33);
        set_m(1, 1, 0, 3'd2, 8'h00);
        wait_done(n0, 4, 40, "alt");
        set_m(0, 0, 0, 3'd0, 8'h00);
        set_m(1, 0, 0, 3'd0, 8'h00);
        if (dcyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("alt_gap", dcyc[i] - dcyc[i-1], 3);
        end else begin
            chk("alt_count", dcyc.size(), 4);
        end
        @(negedge clk);
        #1;

        access(0, 1, 3'd1, 8'hFF, 8'h00, "m0_wr");
        mem[0] = 8'h5A;
        access(1, 0, 3'd0, 8'h00, 8'h5A, "m1_rd");
        access(0, 0, 3'd1, 8'h00, 8'hFF, "m0_rdback");
        access(0, 0, 3'd5, 8'h00, 8'h00, "m0_nop");
        access(1, 1, 3'd6, 8'h77, 8'h00, "m1_nopwr");

        // Requester drops req and changes wdata while the access is in flight
        n0 = ndone;
        expect_acc(0, 1, 3'd3, 8'hA5, 8'h00);
        set_m(0, 1, 1, 3'd3, 8'hA5);
        @(negedge clk);
        #1;
        set_m(0, 0, 0, 3'd0, 8'h00);
        wait_done(n0, 1, 20, "drop");
        @(negedge clk);
        #1;
        access(1, 0, 3'd3, 8'h00, 8'hA5, "m1_rd3");

        // Reset during ISSUE of an m1 write drops the access
        pq.push_back('{1'b1, 3'd1, 8'h42});
        set_m(1, 1, 1, 3'd1, 8'h42);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        set_m(1, 0, 0, 3'd0, 8'h00);
        #1;
        chk("rstmid_a", {29'd0, io_a}, 7);
        chk("rstmid_busy", {31'd0, busy}, 0);
        chk("rstmid_we_n", {31'd0, io_we_n}, 1);
        n0 = ndone;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("rstmid_nodone", ndone, n0);
        chk("rstmid_mem", {24'd0, mem[1]}, 8'hFF);

        // After reset m0 wins the first tie again
        n0 = ndone;
        expect_acc(0, 0, 3'd1, 8'h00, 8'hFF);
        expect_acc(1, 0, 3'd0, 8'h00, 8'h5A);
        set_m(0, 1, 0, 3'd1, 8'h00);
        set_m(1, 1, 0, 3'd0, 8'h00);
        wait_done(n0, 1, 20, "tie1");
        set_m(0, 0, 0, 3'd0, 8'h00);
        wait_done(n0, 2, 20, "tie2");
        set_m(1, 0, 0, 3'd0, 8'h00);
        repeat (4) @(negedge clk);
        #1;

        chk("rq_empty", rq.size(), 0);
        chk("pq_empty", pq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_arb.md
IO_ARB -- requirements
Module: io_arb

Interface
REQ-001 SHALL have these ports: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have these ports: rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have, for each requester N in {0,1}: mN_req (input, 1), the access request, held until done.
REQ-004 SHALL have, per requester: mN_we (input, 1), where 1 means write.
REQ-005 SHALL have, per requester: mN_addr (input, 3), the register select.
REQ-006 SHALL have, per requester: mN_wdata (input, 8), the write data.
REQ-007 SHALL have, per requester: mN_done (output, 1), a one-cycle completion pulse.
REQ-008 SHALL have, per requester: mN_rdata (output, 8), read data, valid only while mN_done=1.
REQ-009 SHALL have io_we_n (output, 1), the active-low write strobe to the port block.
REQ-010 SHALL have io_a (output, 3), the port-block register select.
REQ-011 SHALL have io_di (output, 8), the port-block write data.
REQ-012 SHALL have io_do (input, 8), the port-block read data, registered inside the port block.
REQ-013 SHALL have busy (output, 1), high whenever the FSM is not in IDLE.
REQ-014 SHALL have owner (output, 1), the index of the requester currently granted; it holds its value when idle.

Function
REQ-015 SHALL implement the FSM IDLE -> ISSUE -> RESP -> IDLE, with no other states.
REQ-016 IDLE: if any mN_req=1, the FSM SHALL pick a winner, register its command into io_we_n/io_a/io_di and go to ISSUE; otherwise it stays in IDLE.
REQ-017 Winner selection SHALL be: a single requester wins alone; when both request, the requester other than last_owner wins.
REQ-018 ISSUE SHALL drive the command to the port block for exactly one cycle and then go to RESP.
REQ-019 RESP SHALL assert m<owner>_done=1 for one cycle and then go to IDLE.
REQ-020 In RESP, m<owner>_rdata SHALL equal io_do for a read, and 0x00 for a write or for addr[2]=1.
REQ-021 last_owner SHALL update to owner on the RESP->IDLE transition.
REQ-022 Latency SHALL be: request sampled in IDLE cycle k, command on the port in cycle k+1, done in cycle k+2; throughput is one access per 3 cycles.
REQ-023 Outside ISSUE, the block SHALL drive io_we_n=1 and io_a=3'b111 (the port block's no-op code), and io_di SHALL hold its last value.
REQ-024 For addr[2]=1, ISSUE SHALL drive the no-op code, with no write and no read of the port; done is still returned.
REQ-025 The command SHALL be captured in IDLE; later changes on mN_* inputs SHALL NOT affect the access in flight.
REQ-026 Deassertion of mN_req after grant SHALL NOT abort the access; done is still pulsed.
REQ-027 The non-owner's done SHALL stay 0 and its rdata SHALL be 0x00 at all times.
REQ-028 A requester holding req after done SHALL be treated as a new request in the next IDLE cycle, subject to fairness.

Reset
REQ-029 While rst_n=0, the FSM SHALL be IDLE with last_owner=1, so that m0 wins the first tie.
REQ-030 While rst_n=0, outputs SHALL be: owner=0, busy=0, io_we_n=1, io_a=3'b111, io_di=0x00, all done=0, all rdata=0x00.
REQ-031 Reset asserted in ISSUE or RESP SHALL drop the access; no done is pulsed, even after release.
REQ-032 The first request after rst_n rises SHALL be sampled no earlier than the first rising edge.

Structure
REQ-033 A shared package io_pkg SHALL hold the register addresses (PA=0, DDRA=1, PB=2, DDRB=3), IO_NOP=3'b111 and the FSM state enum.
REQ-034 Tie-break logic SHALL live in a sub-module rr_arb2 (inputs req[1:0] and last_owner; outputs winner and any), which is purely combinational.

Verification
REQ-035 Scenario: m0 writes addr=1 data=0xFF -> io_we_n=0, io_a=1, io_di=0xFF for exactly one cycle; m0_done two cycles after sampling with rdata=0x00.
REQ-036 Scenario: m1 reads addr=0 with io_do=0x5A -> m1_done=1 and m1_rdata=0x5A in cycle k+2; m0_done stays 0.
REQ-037 Scenario: both requesters hold req continuously after reset -> grants alternate m0, m1, m0, m1, with done pulses 3 cycles apart.
REQ-038 Scenario: m0 reads addr=5 -> io_we_n=1 and io_a=3'b111 throughout; m0_done with rdata=0x00.
REQ-039 Scenario: rst_n pulsed low during ISSUE of an m1 write -> no m1_done; io_a=3'b111 and busy=0 immediately.
REQ-040 Scenario: m0 drops req and changes wdata in ISSUE -> the original wdata reaches io_di and m0_done is still pulsed.
